// File: rtl/bram_save_pkg.sv
// Shared types and constants for the backup-RAM save controller.
//   state_t      : controller FSM states
//   start_t      : one-hot request start strobes from the edge arbiter
//   HDR_WORDS    : BRM format header ("HUBM", 0x00881080) as 16-bit words
//   SECTOR_WORDS : 16-bit words per SD sector buffer
package bram_save_pkg;

  localparam int unsigned SECTOR_WORDS = 256;
  localparam int unsigned BUF_W        = $clog2(SECTOR_WORDS);
  localparam int unsigned ADDR_W       = 12;
  localparam int unsigned DATA_W       = 16;
  localparam int unsigned LBA_W        = 32;
  localparam int unsigned TIMER_W      = 24;
  localparam int unsigned HDR_LEN      = 4;

  localparam logic [DATA_W-1:0] HDR_WORDS [HDR_LEN] = '{
    16'h5548, 16'h4D42, 16'h8800, 16'h8010
  };

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FMT,
    ST_ISSUE,
    ST_WAIT_HI,
    ST_WAIT_LO
  } state_t;

  typedef struct packed {
    logic fmt;
    logic load;
    logic save;
  } start_t;

endpackage

// File: rtl/bram_save_ctrl_req_edge_arb.sv
// Rising-edge detection and arbitration of the three user request levels.
//   clk_sys, reset_n : clock, async active-low reset
//   load_req, save_req, format_req : request levels
//   busy    : operation in progress, drops all edges
//   enable  : save image usable, required for load/save only
//   start_c : one-hot start (format > load > save), combinational
module req_edge_arb
  import bram_save_pkg::*;
(
  input  logic   clk_sys,
  input  logic   reset_n,
  input  logic   load_req,
  input  logic   save_req,
  input  logic   format_req,
  input  logic   busy,
  input  logic   enable,
  output start_t start_c
);

  logic [2:0] req_q;
  logic       armed;
  logic       fmt_edge;
  logic       load_edge;
  logic       save_edge;

  // armed stays low for the first cycle after reset so a level that is
  // already high at release is absorbed into req_q without an edge
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      req_q <= '0;
      armed <= 1'b0;
    end else begin
      req_q <= {format_req, load_req, save_req};
      armed <= 1'b1;
    end
  end

  assign fmt_edge  = armed & format_req & ~req_q[2];
  assign load_edge = armed & load_req   & ~req_q[1];
  assign save_edge = armed & save_req   & ~req_q[0];

  // Losing edges are not queued: they simply vanish
  always_comb begin
    start_c = '0;
    if (!busy) begin
      if (fmt_edge)                 start_c.fmt  = 1'b1;
      else if (load_edge && enable) start_c.load = 1'b1;
      else if (save_edge && enable) start_c.save = 1'b1;
    end
  end

endmodule

// File: rtl/bram_save_ctrl.sv
// Backup-RAM load/save/format sequencer between hps_io sector port and
// backram port B.
//   clk_sys, reset_n          : clock, async active-low reset
//   enable                    : save image mounted and writable
//   slot                      : slot index, sampled at accept
//   load_req/save_req/format_req : request levels (rising edge starts)
//   sd_ack, sd_buff_addr, sd_buff_wr, sd_buff_dout : hps_io sector buffer
//   sd_lba, sd_rd, sd_wr      : hps_io sector request
//   bram_addr, bram_din, bram_we : dpram port B
//   busy, loading, error      : status (loading also holds core in reset)
module bram_save_ctrl
  import bram_save_pkg::*;
#(
  parameter int unsigned SECTORS = 16,
  parameter int unsigned SLOT_W  = 2,
  parameter int unsigned TIMEOUT = 32'h0100_0000
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [SLOT_W-1:0] slot,
  input  logic              load_req,
  input  logic              save_req,
  input  logic              format_req,
  input  logic              sd_ack,
  input  logic [BUF_W-1:0]  sd_buff_addr,
  input  logic              sd_buff_wr,
  input  logic [DATA_W-1:0] sd_buff_dout,
  output logic [LBA_W-1:0]  sd_lba,
  output logic              sd_rd,
  output logic              sd_wr,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_din,
  output logic              bram_we,
  output logic              busy,
  output logic              loading,
  output logic              error
);

  localparam int unsigned SECTOR_W = $clog2(SECTORS);
  localparam logic [SECTOR_W-1:0] SECTOR_LAST = SECTOR_W'(SECTORS - 1);
  localparam logic [TIMER_W-1:0]  TIMER_LAST  = TIMER_W'(TIMEOUT - 1);
  localparam logic [1:0]          FMT_LAST    = 2'(HDR_LEN - 1);

  state_t              state;
  start_t              start_c;
  logic [SECTOR_W-1:0] sector;
  logic [1:0]          fmt_idx;
  logic [TIMER_W-1:0]  timer;
  logic                timed_out_c;

  req_edge_arb u_arb (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .load_req   (load_req),
    .save_req   (save_req),
    .format_req (format_req),
    .busy       (busy),
    .enable     (enable),
    .start_c    (start_c)
  );

  assign timed_out_c = (timer == TIMER_LAST);

  // Controller FSM with sector/lba/timer counters and registered status
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      sector  <= '0;
      fmt_idx <= '0;
      timer   <= '0;
      sd_lba  <= '0;
      sd_rd   <= 1'b0;
      sd_wr   <= 1'b0;
      busy    <= 1'b0;
      loading <= 1'b0;
      error   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          timer <= '0;
          if (start_c.fmt) begin
            state   <= ST_FMT;
            fmt_idx <= '0;
            busy    <= 1'b1;
            error   <= 1'b0;
          end else if (start_c.load || start_c.save) begin
            state   <= ST_ISSUE;
            sector  <= '0;
            sd_lba  <= LBA_W'({slot, {SECTOR_W{1'b0}}});
            busy    <= 1'b1;
            loading <= start_c.load;
            error   <= 1'b0;
          end
        end

        ST_FMT: begin
          fmt_idx <= fmt_idx + 2'd1;
          if (fmt_idx == FMT_LAST) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end

        // Request stays up; a stale high ack must fall before we look for a rise
        ST_ISSUE: begin
          sd_rd <= loading;
          sd_wr <= ~loading;
          timer <= '0;
          if (!sd_ack) state <= ST_WAIT_HI;
        end

        ST_WAIT_HI: begin
          if (sd_ack) begin
            sd_rd <= 1'b0;
            sd_wr <= 1'b0;
            timer <= '0;
            state <= ST_WAIT_LO;
          end else if (timed_out_c) begin
            sd_rd   <= 1'b0;
            sd_wr   <= 1'b0;
            error   <= 1'b1;
            busy    <= 1'b0;
            loading <= 1'b0;
            state   <= ST_IDLE;
          end else begin
            timer <= timer + TIMER_W'(1);
          end
        end

        ST_WAIT_LO: begin
          if (!sd_ack) begin
            timer <= '0;
            if (sector == SECTOR_LAST) begin
              busy    <= 1'b0;
              loading <= 1'b0;
              state   <= ST_IDLE;
            end else begin
              sector <= sector + SECTOR_W'(1);
              sd_lba <= sd_lba + LBA_W'(1);
              state  <= ST_ISSUE;
            end
          end else if (timed_out_c) begin
            error   <= 1'b1;
            busy    <= 1'b0;
            loading <= 1'b0;
            state   <= ST_IDLE;
          end else begin
            timer <= timer + TIMER_W'(1);
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  // Port B follows the hps_io buffer strobes directly; idle drives zeros
  always_comb begin
    bram_addr = '0;
    bram_din  = '0;
    bram_we   = 1'b0;
    if (state == ST_FMT) begin
      bram_addr = ADDR_W'(fmt_idx);
      bram_din  = HDR_WORDS[fmt_idx];
      bram_we   = 1'b1;
    end else if (busy) begin
      bram_addr = ADDR_W'({sector, sd_buff_addr});
      if (loading) begin
        bram_din = sd_buff_dout;
        bram_we  = sd_buff_wr & sd_ack;
      end
    end
  end

endmodule

// File: tb/tb_bram_save_ctrl.sv
// Randomized self-checking bench for bram_save_ctrl: hps_io sector model,
// port-B memory scoreboard and request-sequence expectations.
`timescale 1ns/1ps
module tb_bram_save_ctrl;

  localparam int unsigned SECTORS = 16;
  localparam int unsigned SLOT_W  = 2;
  localparam int unsigned TIMEOUT = 1024;
  localparam int unsigned WORDS   = 256;
  localparam int unsigned MEM_N   = SECTORS * WORDS;

  localparam logic [15:0] HDR [4] = '{16'h5548, 16'h4D42, 16'h8800, 16'h8010};

  logic              clk_sys;
  logic              reset_n;
  logic              enable;
  logic [SLOT_W-1:0] slot;
  logic              load_req;
  logic              save_req;
  logic              format_req;
  logic              sd_ack;
  logic [7:0]        sd_buff_addr;
  logic              sd_buff_wr;
  logic [15:0]       sd_buff_dout;
  logic [31:0]       sd_lba;
  logic              sd_rd;
  logic              sd_wr;
  logic [11:0]       bram_addr;
  logic [15:0]       bram_din;
  logic              bram_we;
  logic              busy;
  logic              loading;
  logic              error;

  int n_checks = 0;
  int n_fail   = 0;

  bit          model_en;
  int          ack_lat;
  bit          clr_req;
  logic [31:0] cur_lba;
  logic [15:0] ref_mem [MEM_N];
  logic [15:0] dut_mem [MEM_N];

  int          we_count, addr_err, drop_err, load_err, rd_high, ack_falls;
  logic [31:0] rd_q[$];
  logic [31:0] wr_q[$];
  logic        prev_rd, prev_wr, prev_ack, ack_rose;

  bram_save_ctrl #(
    .SECTORS (SECTORS),
    .SLOT_W  (SLOT_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk_sys      (clk_sys),
    .reset_n      (reset_n),
    .enable       (enable),
    .slot         (slot),
    .load_req     (load_req),
    .save_req     (save_req),
    .format_req   (format_req),
    .sd_ack       (sd_ack),
    .sd_buff_addr (sd_buff_addr),
    .sd_buff_wr   (sd_buff_wr),
    .sd_buff_dout (sd_buff_dout),
    .sd_lba       (sd_lba),
    .sd_rd        (sd_rd),
    .sd_wr        (sd_wr),
    .bram_addr    (bram_addr),
    .bram_din     (bram_din),
    .bram_we      (bram_we),
    .busy         (busy),
    .loading      (loading),
    .error        (error)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // hps_io sector server: latency, then 256 words with ack high
  initial begin : hps_model
    bit          is_rd;
    logic [15:0] d;
    sd_ack = 1'b0; sd_buff_addr = '0; sd_buff_wr = 1'b0; sd_buff_dout = '0; cur_lba = '0;
    forever begin
      @(negedge clk_sys);
      if (model_en && reset_n && (sd_rd || sd_wr)) begin
        is_rd   = sd_rd;
        cur_lba = sd_lba;
        for (int c = 1; c < ack_lat && reset_n; c++) @(negedge clk_sys);
        sd_ack = 1'b1;
        for (int w = 0; w < int'(WORDS) && reset_n; w++) begin
          d            = 16'($urandom);
          sd_buff_addr = 8'(w);
          sd_buff_dout = d;
          sd_buff_wr   = is_rd;
          if (is_rd) ref_mem[{cur_lba[3:0], 8'(w)}] = d;
          @(negedge clk_sys);
        end
        sd_ack = 1'b0; sd_buff_wr = 1'b0; sd_buff_addr = '0;
      end
    end
  end

  // Port-B memory image plus protocol observations
  always @(posedge clk_sys) begin
    if (clr_req) begin
      we_count <= 0; addr_err <= 0; drop_err <= 0; load_err <= 0;
      rd_high <= 0; ack_falls <= 0;
      rd_q.delete(); wr_q.delete();
    end else begin
      if (bram_we) begin
        dut_mem[bram_addr] <= bram_din;
        we_count <= we_count + 1;
      end
      if (sd_rd && !prev_rd) rd_q.push_back(sd_lba);
      if (sd_wr && !prev_wr) wr_q.push_back(sd_lba);
      if (sd_rd && !loading) load_err <= load_err + 1;
      if (sd_rd) rd_high <= rd_high + 1;
      if (!sd_ack && prev_ack) ack_falls <= ack_falls + 1;
      if (busy && sd_ack && !prev_ack && !(sd_rd || sd_wr)) drop_err <= drop_err + 1;
      if (busy && ack_rose && (sd_rd || sd_wr)) drop_err <= drop_err + 1;
      if (busy && sd_ack && bram_addr !== 12'({cur_lba[3:0], sd_buff_addr}))
        addr_err <= addr_err + 1;
    end
    prev_rd  <= sd_rd;
    prev_wr  <= sd_wr;
    prev_ack <= sd_ack;
    ack_rose <= busy && sd_ack && !prev_ack;
  end

  task automatic clear_stats();
    @(negedge clk_sys); clr_req = 1'b1;
    @(negedge clk_sys); clr_req = 1'b0;
  endtask

  task automatic wait_busy(input logic lvl, input int budget, input string tag);
    int n = 0;
    while (busy !== lvl && n < budget) begin
      @(negedge clk_sys);
      n++;
    end
    check_eq(tag, 32'(busy), 32'(lvl));
  endtask

  function automatic int mem_mismatch();
    int m = 0;
    for (int i = 0; i < int'(MEM_N); i++) if (dut_mem[i] !== ref_mem[i]) m++;
    return m;
  endfunction

  task automatic run_load(input logic [1:0] s, input int lat, input bit drop_en);
    clear_stats();
    ack_lat = lat; slot = s; load_req = 1'b1;
    @(negedge clk_sys);
    check_eq("load_accept", 32'(busy), 32'd1);
    check_eq("load_loading", 32'(loading), 32'd1);
    load_req = 1'b0;
    if (drop_en) enable = 1'b0;
    wait_busy(1'b0, 20000, "load_done");
    enable = 1'b1;
    check_eq("load_nsect", 32'(rd_q.size()), SECTORS);
    for (int i = 0; i < rd_q.size() && i < int'(SECTORS); i++)
      check_eq("load_lba", rd_q[i], 32'(s) * SECTORS + 32'(i));
    check_eq("load_no_wr", 32'(wr_q.size()), 32'd0);
    check_eq("load_we_count", 32'(we_count), MEM_N);
    check_eq("load_mem", 32'(mem_mismatch()), 32'd0);
    check_eq("load_addr", 32'(addr_err), 32'd0);
    check_eq("load_rd_drop", 32'(drop_err), 32'd0);
    check_eq("load_loading_hi", 32'(load_err), 32'd0);
    check_eq("load_ack_falls", 32'(ack_falls), SECTORS);
    check_eq("load_loading_end", 32'(loading), 32'd0);
    check_eq("load_error", 32'(error), 32'd0);
  endtask

  task automatic run_save(input logic [1:0] s, input int lat, input bit poke_load);
    clear_stats();
    ack_lat = lat; slot = s; save_req = 1'b1;
    @(negedge clk_sys);
    check_eq("save_accept", 32'(busy), 32'd1);
    check_eq("save_err_clear", 32'(error), 32'd0);
    save_req = 1'b0;
    if (poke_load) begin
      repeat (40) @(negedge clk_sys);
      slot = ~s; load_req = 1'b1;
      repeat (2) @(negedge clk_sys);
      load_req = 1'b0;
    end
    wait_busy(1'b0, 20000, "save_done");
    check_eq("save_nsect", 32'(wr_q.size()), SECTORS);
    for (int i = 0; i < wr_q.size() && i < int'(SECTORS); i++)
      check_eq("save_lba", wr_q[i], 32'(s) * SECTORS + 32'(i));
    check_eq("save_no_rd", 32'(rd_q.size()), 32'd0);
    check_eq("save_no_we", 32'(we_count), 32'd0);
    check_eq("save_addr", 32'(addr_err), 32'd0);
    check_eq("save_wr_drop", 32'(drop_err), 32'd0);
    check_eq("save_loading", 32'(loading), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_rdwr"},  {30'd0, sd_rd, sd_wr}, 32'd0);
    check_eq({tag, "_stat"},  {29'd0, busy, loading, error}, 32'd0);
    check_eq({tag, "_lba"},   sd_lba, 32'd0);
    check_eq({tag, "_bram"},  {3'd0, bram_we, bram_addr, bram_din}, 32'd0);
  endtask

  initial begin : main
    int n;
    reset_n = 1'b0; enable = 1'b1; slot = '0; clr_req = 1'b0;
    load_req = 1'b1; save_req = 1'b0; format_req = 1'b0;
    model_en = 1'b1; ack_lat = 10;
    repeat (3) @(negedge clk_sys);
    check_all_zero("reset");
    reset_n = 1'b1;
    repeat (5) @(negedge clk_sys);
    check_eq("no_edge_at_release", 32'(busy), 32'd0);
    load_req = 1'b0;
    repeat (2) @(negedge clk_sys);

    run_load(2'd2, 10, 1'b0);
    run_save(2'd0, $urandom_range(12, 2), 1'b0);
    run_load(2'($urandom), $urandom_range(12, 2), 1'b1);

    // Simultaneous edges: only the format runs
    clear_stats();
    format_req = 1'b1; load_req = 1'b1; save_req = 1'b1;
    @(negedge clk_sys);
    check_eq("fmt_accept", 32'(busy), 32'd1);
    wait_busy(1'b0, 20, "fmt_done");
    format_req = 1'b0; load_req = 1'b0; save_req = 1'b0;
    repeat (20) @(negedge clk_sys);
    check_eq("fmt_we_count", 32'(we_count), 32'd4);
    for (int i = 0; i < 4; i++) check_eq("fmt_hdr", 32'(dut_mem[i]), 32'(HDR[i]));
    check_eq("fmt_no_sd", 32'(rd_q.size() + wr_q.size()), 32'd0);

    // Disabled image: load ignored, format still allowed
    clear_stats();
    enable = 1'b0; load_req = 1'b1;
    repeat (30) @(negedge clk_sys);
    check_eq("dis_busy", 32'(busy), 32'd0);
    check_eq("dis_no_rd", 32'(rd_q.size()), 32'd0);
    load_req = 1'b0; format_req = 1'b1;
    repeat (10) @(negedge clk_sys);
    format_req = 1'b0;
    check_eq("dis_fmt_we", 32'(we_count), 32'd4);
    enable = 1'b1;

    // Load edge during a save is dropped
    run_save(2'd1, $urandom_range(12, 2), 1'b1);

    // No ack at all: abort after TIMEOUT cycles of request
    model_en = 1'b0;
    clear_stats();
    slot = 2'd1; load_req = 1'b1;
    @(negedge clk_sys);
    load_req = 1'b0;
    wait_busy(1'b0, 4 * TIMEOUT, "tmo_abort");
    check_eq("tmo_rd_cycles", 32'(rd_high), TIMEOUT);
    check_eq("tmo_error", 32'(error), 32'd1);
    check_eq("tmo_rd_low", 32'(sd_rd), 32'd0);
    check_eq("tmo_loading", 32'(loading), 32'd0);
    model_en = 1'b1;
    run_save(2'd3, $urandom_range(12, 2), 1'b0);
    check_eq("err_stays_clear", 32'(error), 32'd0);

    // Reset in the middle of sector 7 of a load
    clear_stats();
    ack_lat = $urandom_range(12, 2); slot = 2'd1; load_req = 1'b1;
    @(negedge clk_sys);
    load_req = 1'b0;
    n = 0;
    while (!(rd_q.size() == 8 && sd_ack) && n < 20000) begin
      @(negedge clk_sys);
      n++;
    end
    check_eq("reach_sector7", 32'(rd_q.size()), 32'd8);
    repeat ($urandom_range(100, 5)) @(negedge clk_sys);
    #2 reset_n = 1'b0;
    #1 check_all_zero("mid_reset");
    repeat (3) @(negedge clk_sys);
    reset_n = 1'b1;
    repeat (3) @(negedge clk_sys);
    run_load(2'd1, $urandom_range(12, 2), 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
